// File: rtl/hub75_pkg.sv
// hub75_pkg: shared definitions for the HUB75 scan engine.
//   - scan state enumeration
//   - mem_rdata channel order and field offsets, as functions of COLOR_BITS
//   - per-plane cycle-count constants and show-counter width helper
package hub75_pkg;

    typedef enum logic [1:0] {
        PREFETCH,
        SHIFT,
        LATCH,
        SHOW
    } state_e;

    // Channel order inside mem_rdata, most significant field first:
    // {r0, g0, b0, r1, g1, b1}.
    localparam int CH_R0  = 0;
    localparam int CH_G0  = 1;
    localparam int CH_B0  = 2;
    localparam int CH_R1  = 3;
    localparam int CH_G1  = 4;
    localparam int CH_B1  = 5;
    localparam int NUM_CH = 6;

    function automatic int field_lsb(input int ch, input int color_bits);
        return (NUM_CH - 1 - ch) * color_bits;
    endfunction

    localparam int PREFETCH_CYCLES      = 1;
    localparam int SHIFT_CYCLES_PER_COL = 2;
    localparam int LATCH_CYCLES         = 1;

    function automatic int plane_cycles(input int cols, input int base_ticks, input int plane);
        return PREFETCH_CYCLES + SHIFT_CYCLES_PER_COL * cols + LATCH_CYCLES + (base_ticks << plane);
    endfunction

    // Wide enough to hold the longest show period (the top plane) without overflow.
    function automatic int show_cnt_w(input int base_ticks, input int color_bits);
        return $clog2(base_ticks << (color_bits - 1)) + 1;
    endfunction

endpackage

// File: rtl/hub75_scan_if.sv
// hub75_scan_if: pixel-memory read bus between the scan engine and the
// dual-pixel frame memory.
//   mem_addr  : {row, col} read address, driven by the scan engine (master)
//   mem_rdata : {r0,g0,b0,r1,g1,b1}, valid one clk after mem_addr (slave)
interface hub75_scan_if #(
    parameter int COLS       = 32,
    parameter int ROW_BITS   = 4,
    parameter int COLOR_BITS = 4
);
    localparam int ADDR_W = ROW_BITS + $clog2(COLS);

    logic [ADDR_W-1:0]       mem_addr;
    logic [6*COLOR_BITS-1:0] mem_rdata;

    modport master (output mem_addr, input mem_rdata);
    modport slave  (input mem_addr, output mem_rdata);
endinterface

// File: rtl/hub75_bcm_timer.sv
// hub75_bcm_timer: show-period timer for binary-code modulation.
//   load       : load BASE_TICKS<<plane (and the dimming limit) for the next SHOW
//   run        : high for every SHOW cycle; counter decrements while high
//   plane      : current bit plane
//   brightness : dimming level, only with HUB75_BRIGHTNESS_EN defined
//   done       : last SHOW cycle
//   oe_n       : 0 while the panel should be lit during SHOW, else 1
// With HUB75_BRIGHTNESS_EN, the first ((BASE_TICKS<<plane)*brightness)>>8
// cycles of SHOW are lit and the remainder stays blanked.
module hub75_bcm_timer
    import hub75_pkg::*;
#(
    parameter int BASE_TICKS = 64,
    parameter int COLOR_BITS = 4,
    parameter int PLANE_W    = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               run,
    input  logic [PLANE_W-1:0] plane,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]         brightness,
`endif
    output logic               done,
    output logic               oe_n
);

    localparam int CW = show_cnt_w(BASE_TICKS, COLOR_BITS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] lim_q, lim_d;
    logic [CW-1:0] ticks;
`ifdef HUB75_BRIGHTNESS_EN
    logic [CW+7:0] prod;
`endif

    always_comb begin
        ticks = CW'(BASE_TICKS) << plane;
        cnt_d = cnt_q;
        lim_d = lim_q;
`ifdef HUB75_BRIGHTNESS_EN
        prod  = {8'd0, ticks} * {{CW{1'b0}}, brightness};
`endif
        if (load) begin
            cnt_d = ticks;
            // The counter runs down from ticks, so "lit while elapsed < threshold"
            // becomes "lit while remaining > ticks - threshold".
`ifdef HUB75_BRIGHTNESS_EN
            lim_d = ticks - CW'(prod >> 8);
`else
            lim_d = '0;
`endif
        end else if (run && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign done = run && (cnt_q == CW'(1));
    assign oe_n = !(run && (cnt_q > lim_q));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            lim_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            lim_q <= lim_d;
        end
    end

endmodule

// File: rtl/hub75_scan.sv
// hub75_scan: HUB75 RGB matrix scan engine with binary-code modulation.
//   clk, reset_n       : clock, asynchronous active-low reset
//   mem (master)       : {row,col} address out, dual-pixel data in (1-cycle latency)
//   brightness[7:0]    : dimming, present only with HUB75_BRIGHTNESS_EN defined
//   led_r0..led_b1     : plane bit for upper (0) / lower (1) half panel
//   led_clk, led_lat   : panel shift clock and latch strobe
//   led_oe             : active-low output enable
//   led_row            : row-pair select
//   frame_done         : one-cycle pulse after the last plane of the last row
// Every pin is a flop fed from the current state, so pins show each state
// one clk after it occurs; this gives colour one clk of setup before each
// led_clk rising edge and places the latch pulse ahead of the lit period.
module hub75_scan
    import hub75_pkg::*;
#(
    parameter int COLS       = 32,
    parameter int ROW_BITS   = 4,
    parameter int COLOR_BITS = 4,
    parameter int BASE_TICKS = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    hub75_scan_if.master        mem,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]          brightness,
`endif
    output logic                led_r0,
    output logic                led_g0,
    output logic                led_b0,
    output logic                led_r1,
    output logic                led_g1,
    output logic                led_b1,
    output logic                led_clk,
    output logic                led_lat,
    output logic                led_oe,
    output logic [ROW_BITS-1:0] led_row,
    output logic                frame_done
);

    localparam int COL_W   = $clog2(COLS);
    localparam int PLANE_W = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int ADDR_W  = ROW_BITS + COL_W;

    state_e                state_q, state_d;
    logic [ROW_BITS-1:0]   row_q, row_d;
    logic [PLANE_W-1:0]    plane_q, plane_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic                  phase_q, phase_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [NUM_CH-1:0]     rgb_q, rgb_d;
    logic                  led_clk_q, led_clk_d;
    logic                  led_lat_q, led_lat_d;
    logic                  led_oe_q, led_oe_d;
    logic [ROW_BITS-1:0]   led_row_q, led_row_d;
    logic                  frame_done_q, frame_done_d;
    logic [COLOR_BITS-1:0] chan;
    logic                  timer_done, timer_oe_n;
`ifdef HUB75_BRIGHTNESS_EN
    logic [7:0]            bright_q, bright_d;
`endif

    hub75_bcm_timer #(
        .BASE_TICKS (BASE_TICKS),
        .COLOR_BITS (COLOR_BITS),
        .PLANE_W    (PLANE_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (state_q == LATCH),
        .run        (state_q == SHOW),
        .plane      (plane_q),
`ifdef HUB75_BRIGHTNESS_EN
        .brightness (bright_q),
`endif
        .done       (timer_done),
        .oe_n       (timer_oe_n)
    );

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        plane_d    = plane_q;
        col_d      = col_q;
        phase_d    = phase_q;
        mem_addr_d = mem_addr_q;
        rgb_d      = rgb_q;
        chan       = '0;
`ifdef HUB75_BRIGHTNESS_EN
        bright_d   = bright_q;
`endif
        case (state_q)
            PREFETCH: begin
                state_d = SHIFT;
                col_d   = '0;
                phase_d = 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
                bright_d = brightness;
`endif
            end
            SHIFT: begin
                if (!phase_q) begin
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        chan      = mem.mem_rdata[field_lsb(ch, COLOR_BITS) +: COLOR_BITS];
                        rgb_d[ch] = chan[plane_q];
                    end
                    // Wraps to col 0 after the last column; that read is never used.
                    mem_addr_d = {row_q, col_q + COL_W'(1)};
                    phase_d    = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    col_d   = col_q + COL_W'(1);
                    if (col_q == COL_W'(COLS - 1)) begin
                        state_d = LATCH;
                    end
                end
            end
            LATCH: begin
                state_d = SHOW;
            end
            SHOW: begin
                if (timer_done) begin
                    state_d = PREFETCH;
                    if (plane_q == PLANE_W'(COLOR_BITS - 1)) begin
                        plane_d = '0;
                        row_d   = row_q + ROW_BITS'(1);
                    end else begin
                        plane_d = plane_q + PLANE_W'(1);
                    end
                    // Address must already be {row,0} while PREFETCH is active.
                    mem_addr_d = {row_d, COL_W'(0)};
                end
            end
            default: begin
                state_d = PREFETCH;
            end
        endcase

        led_clk_d    = (state_q == SHIFT) && phase_q;
        led_lat_d    = (state_q == LATCH);
        led_oe_d     = timer_oe_n;
        led_row_d    = (state_q == LATCH) ? row_q : led_row_q;
        frame_done_d = (state_q == SHOW) && timer_done &&
                       (row_q == {ROW_BITS{1'b1}}) &&
                       (plane_q == PLANE_W'(COLOR_BITS - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= PREFETCH;
            row_q        <= '0;
            plane_q      <= '0;
            col_q        <= '0;
            phase_q      <= 1'b0;
            mem_addr_q   <= '0;
            rgb_q        <= '0;
            led_clk_q    <= 1'b0;
            led_lat_q    <= 1'b0;
            led_oe_q     <= 1'b1;
            led_row_q    <= '0;
            frame_done_q <= 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
            bright_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            plane_q      <= plane_d;
            col_q        <= col_d;
            phase_q      <= phase_d;
            mem_addr_q   <= mem_addr_d;
            rgb_q        <= rgb_d;
            led_clk_q    <= led_clk_d;
            led_lat_q    <= led_lat_d;
            led_oe_q     <= led_oe_d;
            led_row_q    <= led_row_d;
            frame_done_q <= frame_done_d;
`ifdef HUB75_BRIGHTNESS_EN
            bright_q     <= bright_d;
`endif
        end
    end

    assign mem.mem_addr = mem_addr_q;
    assign led_r0       = rgb_q[CH_R0];
    assign led_g0       = rgb_q[CH_G0];
    assign led_b0       = rgb_q[CH_B0];
    assign led_r1       = rgb_q[CH_R1];
    assign led_g1       = rgb_q[CH_G1];
    assign led_b1       = rgb_q[CH_B1];
    assign led_clk      = led_clk_q;
    assign led_lat      = led_lat_q;
    assign led_oe       = led_oe_q;
    assign led_row      = led_row_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_hub75_scan.sv
// tb_hub75_scan: bench for hub75_scan. A frame memory with one-cycle read
// latency feeds the DUT; a negedge monitor checks the panel pins against
// the scan rules (row/plane order, column data per latch, lit-period
// lengths, frame period). Define HUB75_BRIGHTNESS_EN to cover dimming.
module tb_hub75_scan;

    localparam int COLS       = 32;
    localparam int ROW_BITS   = 4;
    localparam int COLOR_BITS = 4;
    localparam int BASE_TICKS = 64;
    localparam int NROWS      = 1 << ROW_BITS;
    localparam int NWORDS     = NROWS * COLS;
    localparam int DW         = 6 * COLOR_BITS;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic led_r0, led_g0, led_b0, led_r1, led_g1, led_b1;
    logic led_clk, led_lat, led_oe, frame_done;
    logic [ROW_BITS-1:0] led_row;
`ifdef HUB75_BRIGHTNESS_EN
    logic [7:0] brightness = 8'd128;
`endif

    hub75_scan_if #(.COLS(COLS), .ROW_BITS(ROW_BITS), .COLOR_BITS(COLOR_BITS)) bus ();

    hub75_scan #(
        .COLS(COLS), .ROW_BITS(ROW_BITS), .COLOR_BITS(COLOR_BITS), .BASE_TICKS(BASE_TICKS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem        (bus),
`ifdef HUB75_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .led_r0     (led_r0),
        .led_g0     (led_g0),
        .led_b0     (led_b0),
        .led_r1     (led_r1),
        .led_g1     (led_g1),
        .led_b1     (led_b1),
        .led_clk    (led_clk),
        .led_lat    (led_lat),
        .led_oe     (led_oe),
        .led_row    (led_row),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [NWORDS];
    always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference rules
    int frame_len;
    int row_len;

    function automatic int show_len(input int p);
        int ticks;
        ticks = BASE_TICKS << p;
`ifdef HUB75_BRIGHTNESS_EN
        return (ticks * int'(brightness)) >> 8;
`else
        return ticks;
`endif
    endfunction

    // Expected {r0,g0,b0,r1,g1,b1} for a pixel pair and plane.
    function automatic logic [5:0] exp_bits(input int row, input int col, input int plane);
        logic [DW-1:0] w;
        logic [5:0] r;
        w = mem[row * COLS + col];
        for (int ch = 0; ch < 6; ch++) r[5 - ch] = w[(5 - ch) * COLOR_BITS + plane];
        return r;
    endfunction

    // Monitor
    int per;
    int exp_row, exp_plane;
    logic [5:0] edges[$];
    logic prev_clk;
    logic [ROW_BITS-1:0] prev_row;
    int oe_run, lat_per, cur_len, next_fd, bad_cols;
    int oe_low_total = 0;
    bit first_edge;
    logic [COLS-1:0] r0_mask [COLOR_BITS];

    always @(negedge clk) begin
        if (!reset_n) begin
            per = 0; exp_row = 0; exp_plane = 0; edges.delete();
            prev_clk = 1'b0; prev_row = '0; oe_run = 0; lat_per = -10;
            cur_len = 0; first_edge = 1'b1; next_fd = frame_len;
            for (int p = 0; p < COLOR_BITS; p++) r0_mask[p] = '0;
        end else begin
            if (led_clk && !prev_clk) begin
                if (first_edge) begin
                    check("first_led_clk_rise_cycle", per, 3);
                    first_edge = 1'b0;
                end
                if (exp_row == 0 && led_r0 && edges.size() < COLS) r0_mask[exp_plane][edges.size()] = 1'b1;
                edges.push_back({led_r0, led_g0, led_b0, led_r1, led_g1, led_b1});
            end
            if (led_lat) begin
                check("shift_edges_per_latch", edges.size(), COLS);
                bad_cols = 0;
                for (int c = 0; c < COLS && c < edges.size(); c++)
                    if (edges[c] != exp_bits(exp_row, c, exp_plane)) bad_cols++;
                check("column_data_bad_cols", bad_cols, 0);
                check("oe_during_latch", led_oe, 1);
                check("row_at_latch", led_row, exp_row);
                cur_len = show_len(exp_plane);
                lat_per = per;
                edges.delete();
                exp_plane++;
                if (exp_plane == COLOR_BITS) begin
                    exp_plane = 0;
                    exp_row = (exp_row + 1) % NROWS;
                end
            end
            if (led_row != prev_row) check("row_change_only_in_latch", led_lat, 1);
            if (!led_oe) begin
                if (oe_run == 0) check("show_follows_latch_gap", per - lat_per, 1);
                oe_run++;
                oe_low_total++;
            end else if (oe_run > 0) begin
                check("oe_low_run_length", oe_run, cur_len);
                oe_run = 0;
            end
            if (frame_done || per == next_fd) begin
                check("frame_done_cycle", frame_done ? per : -1, next_fd);
                next_fd += frame_len;
            end
            prev_clk = led_clk;
            prev_row = led_row;
            per++;
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_colours"}, {led_r0, led_g0, led_b0, led_r1, led_g1, led_b1}, 0);
        check({tag, "_led_clk"}, led_clk, 0);
        check({tag, "_led_lat"}, led_lat, 0);
        check({tag, "_led_oe"}, led_oe, 1);
        check({tag, "_led_row"}, led_row, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    typedef struct {
        int         col;
        logic [3:0] rval;
        logic [3:0] gval;
        logic [3:0] hit;   // planes on which led_r0 must be 1 at edge col+1
    } vec_t;

    vec_t tbl [5];
    int snap;

    initial begin
        #400_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        row_len = 0;
        for (int p = 0; p < COLOR_BITS; p++) row_len += 1 + 2 * COLS + 1 + (BASE_TICKS << p);
        frame_len = row_len * NROWS;
        for (int i = 0; i < NWORDS; i++) mem[i] = '0;

        tbl[0] = '{col: 5,  rval: 4'b0001, gval: 4'b0000, hit: 4'b0001};
        tbl[1] = '{col: 0,  rval: 4'b1010, gval: 4'b0000, hit: 4'b1010};
        tbl[2] = '{col: 31, rval: 4'b1111, gval: 4'b0000, hit: 4'b1111};
        tbl[3] = '{col: 17, rval: 4'b0110, gval: 4'b1001, hit: 4'b0110};
        tbl[4] = '{col: 9,  rval: 4'b0000, gval: 4'b1111, hit: 4'b0000};

        #2 reset_n = 1'b0;
        #1 check_reset_vals("reset_initial");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Column shift vectors: one lit pixel on the top half of row 0.
        for (int i = 0; i < 5; i++) begin
            for (int w = 0; w < NWORDS; w++) mem[w] = '0;
            mem[tbl[i].col] = {tbl[i].rval, tbl[i].gval, {(DW - 8){1'b0}}};
            do_reset();
            repeat (row_len + 10) @(posedge clk);
            for (int p = 0; p < COLOR_BITS; p++)
                check($sformatf("r0_edge_mask_v%0d_p%0d", i, p), r0_mask[p],
                      tbl[i].hit[p] ? (64'd1 << tbl[i].col) : 64'd0);
        end

        // Random frame content over two full frames.
        for (int w = 0; w < NWORDS; w++) mem[w] = DW'($urandom);
        do_reset();
        check("first_mem_addr_prefetch", bus.mem_addr, 0);
        @(posedge clk);
        #1 check("mem_addr_col0", bus.mem_addr, 0);
        @(posedge clk);
        #1 check("mem_addr_col1", bus.mem_addr, 1);
        repeat (2 * frame_len + 50) @(posedge clk);

        // Mid-SHIFT reset in row 1 plane 1.
        repeat (row_len + (1 + 2 * COLS + 1 + (BASE_TICKS << 0))) @(posedge clk);
        check("pre_reset_row_is_1", led_row, 1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("reset_mid_shift");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check("after_release_mem_addr", bus.mem_addr, 0);
        check("after_release_led_row", led_row, 0);
        repeat (row_len + 20) @(posedge clk);

`ifdef HUB75_BRIGHTNESS_EN
        brightness = 8'd0;
        do_reset();
        snap = oe_low_total;
        repeat (row_len + 20) @(posedge clk);
        check("brightness0_oe_low_cycles", oe_low_total - snap, 0);
        brightness = 8'd128;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hub75_scan.md
# hub75_scan

HUB75 scan engine that drives the RGB LED matrix panel pins (led_r0…led_row) from a pixel memory, using binary-code modulation (BCM) for colour depth. Sits inside the matrix component of the system, directly upstream of the panel connector. It reads a dual-pixel memory (upper and lower half-panel) and owns all panel timing: shift clock, latch, output enable and row select.

## Interface
- COLS, 32, pixels per row; power of two, ≥2
- ROW_BITS, 4, row-select width; the panel has 2^ROW_BITS row pairs
- COLOR_BITS, 4, bits per colour channel, i.e. the number of BCM planes
- BASE_TICKS, 64, clk cycles for which plane 0 is shown; plane p is shown for BASE_TICKS<<p

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- mem_addr  out  ROW_BITS+$clog2(COLS)  {row, col} read address
- mem_rdata  in  6*COLOR_BITS  {r0,g0,b0,r1,g1,b1}, each COLOR_BITS wide; valid exactly 1 cycle after mem_addr
- led_r0, led_g0, led_b0, led_r1, led_g1, led_b1  out  1 each  plane bit for upper (0) and lower (1) half
- led_clk  out  1  panel shift clock; data sampled on its rising edge
- led_lat  out  1  latch pulse, active high
- led_oe  out  1  output enable, active low; 1 = blanked
- led_row  out  ROW_BITS  row-pair select
- frame_done  out  1  one-cycle pulse after the last plane of the last row

## Operation
- Loop order: row 0…2^ROW_BITS-1; within each row, plane 0…COLOR_BITS-1; wraps to row 0 plane 0 with no gap.
- States: PREFETCH, SHIFT, LATCH, SHOW.
- PREFETCH (1 cycle): mem_addr={row,0}; led_oe=1.
- SHIFT (2 cycles per column, col 0…COLS-1):
  - phase 0: led_clk=0; the six colour outputs are registered from bit [plane] of each mem_rdata channel; mem_addr advances to col+1 (value unused after the last column).
  - phase 1: led_clk=1; colour outputs held.
- LATCH (1 cycle): led_lat=1, led_clk=0, led_oe=1; led_row takes the current row in this cycle.
- SHOW (BASE_TICKS<<plane cycles): led_oe=0 and led_lat=0. On exit, advance the plane (and the row when the plane wraps) and go to PREFETCH.
- led_oe is 1 in every state except SHOW.
- frame_done is asserted in the cycle after SHOW ends for row 2^ROW_BITS-1, plane COLOR_BITS-1.
- Reset values: colour outputs 0, led_clk 0, led_lat 0, led_oe 1, led_row 0, mem_addr 0, frame_done 0; state PREFETCH with row 0, plane 0, col 0.
- Reset mid-operation: all outputs return to their reset values asynchronously. After release, the scan restarts at row 0, plane 0; no partial latch is issued.
- SHOW counter width is $clog2(BASE_TICKS<<(COLOR_BITS-1))+1 and it must not overflow.

## Timing
- All outputs are registered. No combinational path from mem_rdata to any pin.
- Cycles per plane = 1 + 2*COLS + 1 + (BASE_TICKS<<plane).
- With defaults: 66 cycles plus 64/128/256/512 show cycles; 1224 cycles per row; 19584 cycles per frame.
- The first rising edge of led_clk occurs 3 cycles after PREFETCH is entered.
- The colour setup time to the led_clk rising edge is 1 clk.

## Configuration
- Macro HUB75_BRIGHTNESS_EN.
- Defined: adds input port brightness [7:0]. In SHOW, led_oe=0 only while show_count < ((BASE_TICKS<<plane)*brightness)>>8; the rest of SHOW stays blanked.
  - State duration is unchanged, so frame timing is independent of brightness.
  - brightness is sampled at PREFETCH.
  - brightness=0 means fully blanked.
- Not defined: no port; led_oe=0 for the whole of SHOW.

## Structure
- Package hub75_pkg holds:
  - the state enum (PREFETCH, SHIFT, LATCH, SHOW);
  - the mem_rdata field offsets, as localparam functions of COLOR_BITS;
  - the cycle-count formula constants.
- Sub-module hub75_bcm_timer: loads BASE_TICKS<<plane (and the brightness threshold when enabled), counts down, and produces done and oe_n.

## Test plan
- Reset: assert reset_n=0 mid-SHIFT -> all outputs take their reset values immediately; after release, the first mem_addr is 0 and led_row is 0.
- Column shift: memory returns top r=4'b0001 for column 5 only -> during plane 0, led_r0=1 is present only on the 6th led_clk rising edge; planes 1–3 show led_r0=0.
- Latch/row: run a full row -> exactly 4 one-cycle led_lat pulses, led_row changes only in a LATCH cycle, and led_oe=1 during every led_lat pulse.
- BCM: measure led_oe=0 run lengths within one row -> 64, 128, 256, 512 cycles, and each SHOW follows its latch by 1 cycle.
- Frame: run from reset -> frame_done pulses at cycle 19584 after the first PREFETCH and then every 19584 cycles; led_row wraps 15 -> 0.
- HUB75_BRIGHTNESS_EN defined, brightness=128 -> led_oe=0 run lengths of 32/64/128/256 while the frame period stays 19584; brightness=0 -> led_oe is never 0.
